// File: rtl/cosine_sched.sv
// cosine_sched: queues cosine jobs, launches them one at a time on an external engine, queues results.
// Optional watchdog on the engine wait: define COSINE_SCHED_TIMEOUT_EN.
module cosine_sched #(
  parameter int unsigned JobDepth      = 4,
  parameter int unsigned ResDepth      = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              job_valid_i,
  output logic                              job_ready_o,
  input  logic [31:0]                       job_a_i,
  input  logic [31:0]                       job_b_i,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic [15:0]                       res_cos_o,
  output logic                              res_err_o,
  output logic                              eng_start_o,
  output logic [31:0]                       eng_a_o,
  output logic [31:0]                       eng_b_o,
  input  logic                              eng_done_i,
  input  logic [15:0]                       eng_cos_i,
  output logic                              busy_o,
  output logic [$clog2(JobDepth+1)-1:0]     job_count_o,
  output logic [$clog2(ResDepth+1)-1:0]     res_count_o
);

  localparam int unsigned OpW   = 32;
  localparam int unsigned CosW  = 16;
  localparam int unsigned JPtrW = $clog2(JobDepth);
  localparam int unsigned JCntW = $clog2(JobDepth + 1);
  localparam int unsigned RPtrW = $clog2(ResDepth);
  localparam int unsigned RCntW = $clog2(ResDepth + 1);

  // Elaboration-time parameter sanity check
  if (JobDepth < 2 || (JobDepth & (JobDepth - 1)) != 0 ||
      ResDepth < 2 || (ResDepth & (ResDepth - 1)) != 0 || TimeoutCycles < 1) begin : g_bad_params
    $error("cosine_sched: depths must be powers of two >= 2 and TimeoutCycles >= 1");
  end

  typedef struct packed {
    logic [OpW-1:0] a;
    logic [OpW-1:0] b;
  } job_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DRAIN
  } state_e;

  state_e state_q, state_d;

  job_t             job_mem [JobDepth];
  logic [JPtrW-1:0] job_wr_q, job_rd_q;
  logic [JCntW-1:0] job_cnt_q;
  logic             job_full, job_empty, job_push, job_pop;

  logic [CosW-1:0]  res_cos_mem [ResDepth];
  logic [RPtrW-1:0] res_wr_q, res_rd_q;
  logic [RCntW-1:0] res_cnt_q;
  logic             res_full, res_empty, res_push, res_pop;
  logic [CosW-1:0]  push_cos;

`ifdef COSINE_SCHED_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TimeoutCycles + 1);
  logic [WdW-1:0] wd_q;
  logic           push_err;
  logic           res_err_mem [ResDepth];
`endif

  assign job_full    = (job_cnt_q == JCntW'(JobDepth));
  assign job_empty   = (job_cnt_q == '0);
  assign res_full    = (res_cnt_q == RCntW'(ResDepth));
  assign res_empty   = (res_cnt_q == '0);

  assign job_ready_o = !job_full;
  assign job_push    = job_valid_i && !job_full;
  assign res_valid_o = !res_empty;
  assign res_pop     = res_valid_o && res_ready_i;
  assign res_cos_o   = res_cos_mem[res_rd_q];
  assign job_count_o = job_cnt_q;
  assign res_count_o = res_cnt_q;
  assign eng_start_o = (state_q == ST_LAUNCH);
  assign busy_o      = (state_q != ST_IDLE);

`ifdef COSINE_SCHED_TIMEOUT_EN
  assign res_err_o   = res_err_mem[res_rd_q];
`else
  assign res_err_o   = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Launch/complete sequencing; result space is reserved at launch so the WAIT push cannot overflow
  always_comb begin
    state_d  = state_q;
    job_pop  = 1'b0;
    res_push = 1'b0;
    push_cos = eng_cos_i;
`ifdef COSINE_SCHED_TIMEOUT_EN
    push_err = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!job_empty && !res_full && !eng_done_i) begin
          job_pop = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_done_i) begin
          res_push = 1'b1;
          state_d  = ST_DRAIN;
        end
`ifdef COSINE_SCHED_TIMEOUT_EN
        else if (wd_q == WdW'(TimeoutCycles - 1)) begin
          res_push = 1'b1;
          push_err = 1'b1;
          push_cos = '0;
          state_d  = ST_DRAIN;
        end
`endif
      end
      ST_DRAIN: begin
        if (!eng_done_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef COSINE_SCHED_TIMEOUT_EN
  // Counts completed WAIT cycles; a done in the limit cycle takes priority above
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  wd_q <= '0;
    else if (state_q == ST_WAIT)  wd_q <= WdW'(wd_q + 1'b1);
    else                          wd_q <= '0;
  end
`endif

  // Job FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      job_wr_q  <= '0;
      job_rd_q  <= '0;
      job_cnt_q <= '0;
    end else begin
      if (job_push) job_wr_q <= JPtrW'(job_wr_q + 1'b1);
      if (job_pop)  job_rd_q <= JPtrW'(job_rd_q + 1'b1);
      case ({job_push, job_pop})
        2'b10:   job_cnt_q <= JCntW'(job_cnt_q + 1'b1);
        2'b01:   job_cnt_q <= JCntW'(job_cnt_q - 1'b1);
        default: job_cnt_q <= job_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (job_push) job_mem[job_wr_q] <= '{a: job_a_i, b: job_b_i};
  end

  // Engine operands stay put from LAUNCH until the next job is popped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eng_a_o <= '0;
      eng_b_o <= '0;
    end else if (job_pop) begin
      eng_a_o <= job_mem[job_rd_q].a;
      eng_b_o <= job_mem[job_rd_q].b;
    end
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      if (res_push) res_wr_q <= RPtrW'(res_wr_q + 1'b1);
      if (res_pop)  res_rd_q <= RPtrW'(res_rd_q + 1'b1);
      case ({res_push, res_pop})
        2'b10:   res_cnt_q <= RCntW'(res_cnt_q + 1'b1);
        2'b01:   res_cnt_q <= RCntW'(res_cnt_q - 1'b1);
        default: res_cnt_q <= res_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (res_push) begin
      res_cos_mem[res_wr_q] <= push_cos;
`ifdef COSINE_SCHED_TIMEOUT_EN
      res_err_mem[res_wr_q] <= push_err;
`endif
    end
  end

endmodule

// File: tb/tb_cosine_sched.sv
// Scoreboard bench for cosine_sched: directed jobs, behavioural engine, decoupled result monitor.
module tb_cosine_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid_i, job_ready_o;
  logic [31:0] job_a_i, job_b_i;
  logic        res_valid_o, res_ready_i, res_err_o;
  logic [15:0] res_cos_o;
  logic        eng_start_o, eng_done_i;
  logic [31:0] eng_a_o, eng_b_o;
  logic [15:0] eng_cos_i;
  logic        busy_o;
  logic [2:0]  job_count_o, res_count_o;

  always #5 clk = ~clk;

  cosine_sched #(.JobDepth(4), .ResDepth(4), .TimeoutCycles(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_a_i(job_a_i), .job_b_i(job_b_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_cos_o(res_cos_o), .res_err_o(res_err_o),
    .eng_start_o(eng_start_o), .eng_a_o(eng_a_o), .eng_b_o(eng_b_o),
    .eng_done_i(eng_done_i), .eng_cos_i(eng_cos_i),
    .busy_o(busy_o), .job_count_o(job_count_o), .res_count_o(res_count_o)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] cos;
  } eng_job_t;

  eng_job_t    eng_q [$];
  logic [16:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;
  int eng_lat  = 1;   // 0 = stall until eng_cmd changes
  int eng_hold = 1;
  int eng_cmd  = 0;   // 1 = release stalled done, 2 = drop stalled job

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural engine: serves launches in order from eng_q
  initial begin : engine
    eng_job_t j;
    bit abort, saw;
    int lat, hold, waited;
    eng_done_i = 1'b0;
    eng_cos_i  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && eng_start_o) begin
        n_starts++;
        lat = eng_lat;
        hold = eng_hold;
        abort = 1'b0;
        if (eng_q.size() == 0) begin
          check("spurious_start", 1, 0);
        end else begin
          j = eng_q.pop_front();
          check("launch_a", eng_a_o, j.a);
          check("launch_b", eng_b_o, j.b);
          if (lat == 0) begin
            waited = 0;
            while (eng_cmd == 0 && !abort) begin
              @(negedge clk);
              waited++;
              if (!rst_n) abort = 1'b1;
              else if (waited > 20000) begin
                check("engine_stall_bound", waited, 0);
                abort = 1'b1;
              end
            end
            if (eng_cmd == 2) abort = 1'b1;
          end else begin
            for (int i = 0; i < lat && !abort; i++) begin
              @(negedge clk);
              if (!rst_n) abort = 1'b1;
            end
          end
          if (!abort) begin
            check("wait_a_stable", eng_a_o, j.a);
            check("wait_b_stable", eng_b_o, j.b);
            eng_done_i = 1'b1;
            eng_cos_i  = j.cos;
            saw = 1'b0;
            for (int h = 0; h < hold; h++) begin
              @(negedge clk);
              if (eng_start_o) saw = 1'b1;
            end
            eng_done_i = 1'b0;
            check("no_launch_while_done", saw, 0);
            check("drain_a_stable", eng_a_o, j.a);
          end
        end
      end
    end
  end

  // Scoreboard monitor: compares each popped result against the queue
  logic [16:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n && res_valid_o && res_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {res_err_o, res_cos_o}, 17'h1FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {res_err_o, res_cos_o}, mon_exp);
      end
    end
  end

  task automatic push_job(input logic [31:0] a, input logic [31:0] b, input logic [15:0] cos);
    bit rdy;
    int n;
    eng_job_t j;
    job_valid_i = 1'b1;
    job_a_i = a;
    job_b_i = b;
    n = 0;
    do begin
      @(negedge clk);
      rdy = job_ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    job_valid_i = 1'b0;
    if (rdy) begin
      j.a = a; j.b = b; j.cos = cos;
      eng_q.push_back(j);
      exp_q.push_back({1'b0, cos});
    end else begin
      check("push_accept_bound", 0, 1);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 3000 && !(exp_q.size() == 0 && eng_q.size() == 0 && !busy_o && job_count_o == 0)) begin
      @(negedge clk);
      n++;
    end
    check(name, n < 3000, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res_count(input int cnt);
    int n;
    n = 0;
    while (n < 500 && int'(res_count_o) != cnt) begin
      @(negedge clk);
      n++;
    end
    check("res_count_reached", res_count_o, cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin : global_bound
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time bound expired");
  end

  initial begin : stim
    int k, s0;
    job_valid_i = 1'b0;
    job_a_i = '0;
    job_b_i = '0;
    res_ready_i = 1'b1;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_job_ready", job_ready_o, 1);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_job_count", job_count_o, 0);
    check("rst_res_count", res_count_o, 0);
    check("rst_start", eng_start_o, 0);
    check("rst_eng_ab", {eng_a_o, eng_b_o}, 64'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Minimum push-to-result latency
    eng_lat = 1; eng_hold = 1;
    push_job(32'h1111_0001, 32'h2222_0002, 16'h1234);
    k = 0;
    while (k < 10 && !res_valid_o) begin
      @(negedge clk);
      k++;
    end
    check("min_latency", k, 4);
    @(posedge clk); #1;
    wait_done("lat_done");

    // Single job, engine answers after 10 cycles
    s0 = n_starts;
    eng_lat = 10;
    push_job(32'h0001_0002, 32'h0001_0002, 16'h7FFF);
    wait_done("single_done");
    check("single_start_pulses", n_starts - s0, 1);

    // Job FIFO fills behind a stalled engine; 5th refused until next launch
    eng_lat = 0; eng_cmd = 0;
    push_job(32'hA000_0000, 32'hB000_0000, 16'h0A00);
    push_job(32'hA000_0001, 32'hB000_0001, 16'h0A01);
    push_job(32'hA000_0002, 32'hB000_0002, 16'h0A02);
    push_job(32'hA000_0003, 32'hB000_0003, 16'h0A03);
    push_job(32'hA000_0004, 32'hB000_0004, 16'h0A04);
    @(negedge clk);
    check("full_job_count", job_count_o, 4);
    check("full_busy", busy_o, 1);
    @(posedge clk); #1;
    job_valid_i = 1'b1; job_a_i = 32'hA000_0005; job_b_i = 32'hB000_0005;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fifth_refused", job_ready_o, 0);
      @(posedge clk); #1;
    end
    eng_lat = 2;
    eng_cmd = 1;
    push_job(32'hA000_0005, 32'hB000_0005, 16'h0A05);
    wait_done("order_done");

    // Result FIFO full blocks launch; one pop re-enables it
    eng_lat = 1; eng_cmd = 0;
    res_ready_i = 1'b0;
    push_job(32'hC000_0000, 32'hD000_0000, 16'h0C00);
    push_job(32'hC000_0001, 32'hD000_0001, 16'h0C01);
    push_job(32'hC000_0002, 32'hD000_0002, 16'h0C02);
    push_job(32'hC000_0003, 32'hD000_0003, 16'h0C03);
    wait_res_count(4);
    s0 = n_starts;
    push_job(32'hC000_0004, 32'hD000_0004, 16'h0C04);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("resfull_busy", busy_o, 0);
    check("resfull_job_count", job_count_o, 1);
    check("resfull_no_start", n_starts - s0, 0);
    @(posedge clk); #1;
    res_ready_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    res_ready_i = 1'b0;
    k = 0;
    while (k < 4 && !eng_start_o) begin
      @(negedge clk);
      k++;
    end
    check("launch_after_pop", k, 2);
    @(posedge clk); #1;
    res_ready_i = 1'b1;
    wait_done("resfull_done");

    // Sticky done held 20 cycles with a second job queued
    s0 = n_starts;
    eng_lat = 1; eng_hold = 20;
    push_job(32'hE000_0000, 32'hF000_0000, 16'h0E00);
    push_job(32'hE000_0001, 32'hF000_0001, 16'h0E01);
    wait_done("sticky_done");
    check("sticky_starts", n_starts - s0, 2);
    eng_hold = 1;

`ifdef COSINE_SCHED_TIMEOUT_EN
    // Watchdog expiry, then a done landing exactly on the limit
    eng_lat = 0; eng_cmd = 0;
    push_job(32'h5555_0000, 32'h6666_0000, 16'h5555);
    exp_q[exp_q.size()-1] = 17'h1_0000;
    k = 0;
    while (k < 10 && !eng_start_o) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (k < 40 && !res_valid_o) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", k, 17);
    @(posedge clk); #1;
    eng_cmd = 2;
    wait_done("timeout_done");
    eng_lat = 16; eng_cmd = 0;
    push_job(32'h5555_0001, 32'h6666_0001, 16'h0BEE);
    wait_done("limit_done_wins");
`endif

    // Reset mid-job discards everything
    eng_lat = 1; eng_cmd = 0;
    res_ready_i = 1'b0;
    push_job(32'h7000_0000, 32'h8000_0000, 16'h0700);
    wait_res_count(1);
    eng_lat = 0;
    push_job(32'h7000_0001, 32'h8000_0001, 16'h0701);
    push_job(32'h7000_0002, 32'h8000_0002, 16'h0702);
    push_job(32'h7000_0003, 32'h8000_0003, 16'h0703);
    @(negedge clk);
    check("pre_rst_job_count", job_count_o, 2);
    check("pre_rst_res_count", res_count_o, 1);
    check("pre_rst_busy", busy_o, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_job_count", job_count_o, 0);
    check("async_rst_res_count", res_count_o, 0);
    check("async_rst_res_valid", res_valid_o, 0);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_job_ready", job_ready_o, 1);
    check("async_rst_eng_a", eng_a_o, 0);
    exp_q.delete();
    eng_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    res_ready_i = 1'b1;
    s0 = n_starts;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_start", n_starts - s0, 0);
    check("post_rst_res_valid", res_valid_o, 0);
    check("post_rst_busy", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
